// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared defines: core opcodes, FSM encodings, responder defaults
package data_mem_responder_pkg;

  // Core memory opcodes that drive req/we into the responder
  localparam logic [3:0] OPC_LOAD  = 4'hA;
  localparam logic [3:0] OPC_STORE = 4'hB;

  // Responder defaults
  localparam int DEF_WAIT_STATES     = 2;
  localparam int DEF_ADDR_WORDS_LOG2 = 8;

  // Access FSM encodings
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // A word address is in range when no bit at or above aw is set
  function automatic logic word_in_range(input logic [14:0] word, input int aw);
    return (word >> aw) == 15'd0;
  endfunction

endpackage

// File: rtl/data_mem_responder_sram_1rw.sv
// rtl/data_mem_responder_sram_1rw.sv - single-port SRAM, synchronous write, registered read
module sram_1rw #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  i_clk,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [WIDTH-1:0]      i_wdata,
  output logic [WIDTH-1:0]      o_q
);

  logic [WIDTH-1:0] r_mem [2**DEPTH_LOG2];
  logic [WIDTH-1:0] r_q;

  // Write on enabled store; read port only updates on an enabled load
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end else begin
        r_q <= r_mem[i_addr];
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - wait-state data memory responder for the core load/store port
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int WAIT_STATES     = DEF_WAIT_STATES,
  parameter int ADDR_WORDS_LOG2 = DEF_ADDR_WORDS_LOG2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        ack,
  output logic [15:0] rdata,
  output logic        err,
  output logic        busy
);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [14:0] r_word;
  logic [15:0] r_wdata;
  logic        r_resp_err;
  logic        r_resp_load;
  logic        r_ack;
  logic        r_err;
  logic        r_busy;
  logic [15:0] r_rdata;

  logic        w_accept;
  logic        w_go_resp;
  logic        w_acc_we;
  logic [14:0] w_acc_word;
  logic [15:0] w_acc_wdata;
  logic        w_in_range;
  logic [15:0] w_q;
  logic        w_unused_addr0;

  // Byte lane select is irrelevant for word accesses
  assign w_unused_addr0 = addr[0];

  assign w_accept = (r_state == ST_IDLE) && req;

  // With zero wait states the access happens on the accepting edge, so it
  // must use the live inputs; otherwise it uses the captured copies
  assign w_acc_we    = (r_state == ST_IDLE) ? we         : r_we;
  assign w_acc_word  = (r_state == ST_IDLE) ? addr[15:1] : r_word;
  assign w_acc_wdata = (r_state == ST_IDLE) ? wdata      : r_wdata;
  assign w_in_range  = word_in_range(w_acc_word, ADDR_WORDS_LOG2);

  assign w_go_resp = (w_accept && (WAIT_STATES == 0)) ||
                     ((r_state == ST_WAIT) && (r_cnt == 4'd1));

  // Out-of-range accesses never enable the array, so stores are dropped
  sram_1rw #(
    .WIDTH      (16),
    .DEPTH_LOG2 (ADDR_WORDS_LOG2)
  ) u_sram (
    .i_clk   (clk),
    .i_en    (w_go_resp && w_in_range),
    .i_we    (w_acc_we),
    .i_addr  (w_acc_word[ADDR_WORDS_LOG2-1:0]),
    .i_wdata (w_acc_wdata),
    .o_q     (w_q)
  );

  // Access FSM: capture, count wait states, access, then report ack/err/rdata
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_word      <= 15'd0;
      r_wdata     <= 16'd0;
      r_resp_err  <= 1'b0;
      r_resp_load <= 1'b0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_rdata     <= 16'd0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      if (w_go_resp) begin
        r_resp_err  <= ~w_in_range;
        r_resp_load <= ~w_acc_we;
      end
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_we    <= we;
            r_word  <= addr[15:1];
            r_wdata <= wdata;
            r_cnt   <= 4'(WAIT_STATES);
            r_busy  <= 1'b1;
            r_state <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          // ack/err/rdata are registered off the RESP cycle
          r_state <= ST_IDLE;
          r_cnt   <= 4'd0;
          r_busy  <= 1'b0;
          r_ack   <= 1'b1;
          r_err   <= r_resp_err;
          if (r_resp_load) begin
            r_rdata <= r_resp_err ? 16'h0000 : w_q;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ack   = r_ack;
  assign err   = r_err;
  assign busy  = r_busy;
  assign rdata = r_rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder at two wait-state settings
module tb_data_mem_responder;

  typedef struct {
    logic        err;
    logic [15:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  // WAIT_STATES=2 instance
  logic        reset2, req2, we2, ack2, err2, busy2;
  logic [15:0] addr2, wdata2, rdata2;
  // WAIT_STATES=0 instance
  logic        reset0, req0, we0, ack0, err0, busy0;
  logic [15:0] addr0, wdata0, rdata0;

  data_mem_responder #(.WAIT_STATES(2), .ADDR_WORDS_LOG2(8)) u_dut2 (
    .clk(clk), .reset(reset2), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
    .ack(ack2), .rdata(rdata2), .err(err2), .busy(busy2)
  );

  data_mem_responder #(.WAIT_STATES(0), .ADDR_WORDS_LOG2(8)) u_dut0 (
    .clk(clk), .reset(reset0), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .ack(ack0), .rdata(rdata0), .err(err0), .busy(busy0)
  );

  int n_total = 0;
  int n_pass  = 0;

  exp_t q2[$];
  exp_t q0[$];
  logic [15:0] mem_m [int];
  logic [15:0] lr_m [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: 256 words, byte address bit 0 ignored, rdata holds last load
  function automatic exp_t model(input int di, input logic w, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    int   key;
    key   = di * 65536 + int'(a[15:1]);
    e.err = (a[15:9] != 7'd0);
    if (w) begin
      if (!e.err) mem_m[key] = d;
      e.rdata = lr_m[di];
    end else begin
      if (e.err)                 e.rdata = 16'h0000;
      else if (mem_m.exists(key)) e.rdata = mem_m[key];
      else                       e.rdata = 16'h0000;
      lr_m[di] = e.rdata;
    end
    return e;
  endfunction

  // One access on the WAIT_STATES=2 instance; entered and left just after a rising edge
  task automatic acc2(input logic w, input logic [15:0] a, input logic [15:0] d, input bit scr);
    int   k;
    bit   got;
    exp_t e;
    req2 = 1'b1; we2 = w; addr2 = a; wdata2 = d;
    q2.push_back(model(1, w, a, d));
    @(posedge clk); #1;
    req2 = 1'b0;
    got = 1'b0;
    k = 0;
    while (!got && k < 12) begin
      if (scr) begin
        addr2  = 16'($urandom);
        wdata2 = 16'($urandom);
        we2    = ~we2;
      end
      @(negedge clk);
      if (k == 0) check("ws2_busy_after_accept", busy2, 1);
      if (ack2) begin
        got = 1'b1;
        e = q2.pop_front();
        check("ws2_ack_latency", k, 3);
        check("ws2_busy_in_ack", busy2, 0);
        check("ws2_err", err2, e.err);
        check("ws2_rdata", rdata2, e.rdata);
      end else begin
        @(posedge clk); #1;
        k++;
      end
    end
    check("ws2_ack_seen", got, 1);
    if (!got && q2.size() > 0) void'(q2.pop_front());
    @(negedge clk);
    check("ws2_ack_one_cycle", ack2, 0);
    check("ws2_err_cleared", err2, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit   saw;
    logic nw;
    logic [15:0] nd;
    exp_t e;

    lr_m[0] = 16'h0000; lr_m[1] = 16'h0000;
    reset2 = 1'b0; req2 = 1'b0; we2 = 1'b0; addr2 = '0; wdata2 = '0;
    reset0 = 1'b0; req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;

    // Reset state
    #2;
    check("rst_ack", ack2, 0);
    check("rst_busy", busy2, 0);
    check("rst_err", err2, 0);
    check("rst_rdata", rdata2, 16'h0000);
    check("rst_busy0", busy0, 0);

    // Release; first request taken on the very next rising edge
    @(posedge clk); #1;
    reset2 = 1'b1; reset0 = 1'b1;
    acc2(1'b1, 16'h0010, 16'hBEEF, 1'b0);
    acc2(1'b0, 16'h0011, 16'h0000, 1'b0);
    // Inputs scrambled during WAIT must not disturb the captured store
    acc2(1'b1, 16'h0030, 16'h5A5A, 1'b1);
    acc2(1'b0, 16'h0030, 16'h0000, 1'b1);
    // Out-of-range store/load and aliasing check on word 0
    acc2(1'b1, 16'h0000, 16'h1111, 1'b0);
    acc2(1'b1, 16'h0200, 16'h1234, 1'b0);
    acc2(1'b0, 16'h0200, 16'h0000, 1'b0);
    acc2(1'b0, 16'h0000, 16'h0000, 1'b0);
    acc2(1'b1, 16'h0020, 16'h7777, 1'b0);
    acc2(1'b0, 16'h0020, 16'h0000, 1'b0);

    // Store aborted by reset mid-WAIT
    req2 = 1'b1; we2 = 1'b1; addr2 = 16'h0020; wdata2 = 16'hDEAD;
    @(posedge clk); #1;
    req2 = 1'b0;
    @(posedge clk); #1;
    check("abort_busy_before", busy2, 1);
    check("abort_rdata_before", rdata2, 16'h7777);
    #2 reset2 = 1'b0;
    #1;
    check("abort_busy_now", busy2, 0);
    check("abort_ack_now", ack2, 0);
    check("abort_err_now", err2, 0);
    check("abort_rdata_now", rdata2, 16'h0000);
    @(posedge clk); @(posedge clk); #1;
    reset2 = 1'b1;
    lr_m[1] = 16'h0000;
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ack2) saw = 1'b1;
    end
    check("abort_no_ack_after_release", saw, 0);
    @(posedge clk); #1;
    acc2(1'b0, 16'h0020, 16'h0000, 1'b0);

    // WAIT_STATES=0: req held high, alternating store/load to one word
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0004; wdata0 = 16'hA000;
    q0.push_back(model(0, 1'b1, 16'h0004, 16'hA000));
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i < 7) begin
        nw = ((i + 1) % 2 == 0);
        nd = 16'hA000 + 16'(i + 1);
        we0 = nw; wdata0 = nd;
        q0.push_back(model(0, nw, 16'h0004, nd));
      end else begin
        req0 = 1'b0;
      end
      @(negedge clk);
      check("ws0_resp_no_ack", ack0, 0);
      check("ws0_resp_busy", busy0, 1);
      @(posedge clk); #1;
      @(negedge clk);
      check("ws0_ack", ack0, 1);
      check("ws0_idle_busy", busy0, 0);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check("ws0_err", err0, e.err);
        check("ws0_rdata", rdata0, e.rdata);
      end
    end
    @(negedge clk);
    check("ws0_quiet_after", ack0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
